// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Instruction fetch unit. Issues one request at a time to
//               instruction memory, holds the returned word for
//               decode with a valid/ready handshake, and handles taken-branch
//               redirects, including squashing an in-flight response.
//               Optional macro FETCH_PERF_CNT_EN adds fetch_count and
//               flush_count performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [6:0]  opcode,
  output logic [31:0] pc_out,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_base,
  input  logic [31:0] redirect_imm
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
`endif
);

  // S_IDLE is the fetch-pending state held during reset; FETCH follows one
  // edge after reset release so no request is issued while reset is active.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic        r_flush;
  logic        w_flush_next;
  logic [31:0] r_instr;
  logic [31:0] r_pc_out;
  logic        r_out_valid;
  logic        w_latch;
  logic        w_accept;
  logic        w_squash;
  logic [31:0] w_target;

  // Branch immediate is a halfword offset; wraps modulo 2^32.
  assign w_target = redirect_base + (redirect_imm << 1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next state, pc/flush update, memory request and handshake decode.
  always_comb begin
    w_next_state = r_state;
    w_pc_next    = r_pc;
    w_flush_next = r_flush;
    w_latch      = 1'b0;
    w_accept     = 1'b0;
    w_squash     = 1'b0;
    imem_req     = 1'b0;
    imem_addr    = 32'h0000_0000;
    unique case (r_state)
      S_IDLE: begin
        w_next_state = S_FETCH;
      end
      S_FETCH: begin
        imem_req     = 1'b1;
        imem_addr    = r_pc;
        w_next_state = S_WAIT;
        if (redirect_valid) begin
          w_pc_next    = w_target;
          w_flush_next = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (redirect_valid || r_flush) begin
            // Response belongs to the wrong path: drop it and refetch.
            w_squash     = 1'b1;
            w_flush_next = 1'b0;
            w_next_state = S_FETCH;
            if (redirect_valid) w_pc_next = w_target;
          end else begin
            w_latch      = 1'b1;
            w_next_state = S_HOLD;
          end
        end else if (redirect_valid) begin
          w_pc_next    = w_target;
          w_flush_next = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          // A simultaneous handshake still counts; the branch target wins.
          w_accept     = out_ready;
          w_squash     = ~out_ready;
          w_pc_next    = w_target;
          w_next_state = S_FETCH;
        end else if (out_ready) begin
          w_accept     = 1'b1;
          w_pc_next    = r_pc + 32'd4;
          w_next_state = S_FETCH;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // PC, flush-pending flag and the held instruction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_flush     <= 1'b0;
      r_instr     <= 32'h0000_0000;
      r_pc_out    <= 32'h0000_0000;
      r_out_valid <= 1'b0;
    end else begin
      r_pc    <= w_pc_next;
      r_flush <= w_flush_next;
      if (w_latch) begin
        r_instr     <= imem_rdata;
        r_pc_out    <= r_pc;
        r_out_valid <= 1'b1;
      end else if (r_state == S_HOLD && w_next_state == S_FETCH) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign instruction = r_instr;
  assign opcode      = r_instr[6:0];
  assign pc_out      = r_pc_out;
  assign out_valid   = r_out_valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_flush_count;

  // Completed handshakes and dropped/discarded instructions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= 32'h0000_0000;
      r_flush_count <= 32'h0000_0000;
    end else begin
      if (w_accept) r_fetch_count <= r_fetch_count + 32'd1;
      if (w_squash) r_flush_count <= r_flush_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
  assign flush_count = r_flush_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit. A random-latency
//               memory and a transaction-level reference model predict
//               every request address, held instruction and valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [6:0]  opcode;
  logic [31:0] pc_out;
  logic        out_valid;
  logic        out_ready;
  logic        redirect_valid;
  logic [31:0] redirect_base;
  logic [31:0] redirect_imm;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] flush_count;
`endif

  instr_fetch_unit #(.RESET_PC(c_RESET_PC)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instruction    (instruction),
    .opcode         (opcode),
    .pc_out         (pc_out),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .redirect_valid (redirect_valid),
    .redirect_base  (redirect_base),
    .redirect_imm   (redirect_imm)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count),
    .flush_count    (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one outstanding memory transaction, next fetch
  // address, and the instruction currently offered downstream.
  int          cyc       = 0;
  int          force_lat = 0;
  bit          m_out;
  int          m_due;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  bit          m_drop;
  logic [31:0] m_pc;
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pcout;
  bit          m_req;
  logic [31:0] m_fetch;
  logic [31:0] m_flush;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out   = 1'b0;
    m_drop  = 1'b0;
    m_pc    = c_RESET_PC;
    m_valid = 1'b0;
    m_req   = 1'b1;
    m_fetch = 32'd0;
    m_flush = 32'd0;
  endtask

  // One clock cycle: compare DUT outputs with the model, drive inputs,
  // advance the model, then move to #1 after the next rising edge.
  task automatic step(input bit rdy, input bit redir_in,
                      input logic [31:0] base, input logic [31:0] imm);
    bit          deliver;
    bit          redir;
    logic [31:0] tgt;
    int          lat;
    chk("imem_req", 32'(imem_req), 32'(m_req));
    if (m_req) begin
      chk("imem_addr", imem_addr, m_pc);
      lat    = (force_lat != 0) ? force_lat : int'($urandom_range(1, 4));
      m_out  = 1'b1;
      m_addr = m_pc;
      m_due  = cyc + lat;
      m_data = $urandom;
    end
    m_req = 1'b0;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("instruction", instruction, m_instr);
      chk("opcode", 32'(opcode), 32'(m_instr[6:0]));
      chk("pc_out", pc_out, m_pcout);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_count", fetch_count, m_fetch);
    chk("flush_count", flush_count, m_flush);
`endif
    deliver        = m_out && (cyc == m_due);
    redir          = redir_in && (m_out || m_valid);
    imem_rvalid    = deliver;
    imem_rdata     = deliver ? m_data : $urandom;
    out_ready      = rdy;
    redirect_valid = redir;
    redirect_base  = base;
    redirect_imm   = imm;
    tgt            = base + imm * 2;
    if (m_valid) begin
      if (redir || rdy) begin
        m_valid = 1'b0;
        m_req   = 1'b1;
        if (rdy) m_fetch = m_fetch + 1;
        else     m_flush = m_flush + 1;
        m_pc = redir ? tgt : m_pcout + 32'd4;
      end
    end else if (m_out) begin
      if (deliver) begin
        m_out = 1'b0;
        if (redir || m_drop) begin
          m_drop  = 1'b0;
          m_flush = m_flush + 1;
          m_req   = 1'b1;
          if (redir) m_pc = tgt;
        end else begin
          m_valid = 1'b1;
          m_instr = m_data;
          m_pcout = m_addr;
        end
      end else if (redir) begin
        m_pc   = tgt;
        m_drop = 1'b1;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset with a response arriving while in reset and a stray
  // response in the cycle after release.
  task automatic do_reset();
    rst_n          = 1'b0;
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_instruction", instruction, 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    imem_rvalid = 1'b1;
    imem_rdata  = $urandom;
    @(posedge clk);
    #1;
    chk("rst_hold_out_valid", 32'(out_valid), 32'd0);
    chk("rst_hold_imem_req", 32'(imem_req), 32'd0);
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = $urandom;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to_fetch();
    for (int i = 0; i < 20 && !m_req; i++) step(1'b1, 1'b0, 32'd0, 32'd0);
    chk("reach_fetch", 32'(m_req), 32'd1);
  endtask

  task automatic go_to_hold();
    for (int i = 0; i < 20 && !m_valid; i++) step(1'b0, 1'b0, 32'd0, 32'd0);
    chk("reach_hold", 32'(m_valid), 32'd1);
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'd0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_base  = 32'd0;
    redirect_imm   = 32'd0;
    @(posedge clk);
    #1;
    do_reset();

    // Latency 1, always ready: addresses 0,4,8 back to back.
    force_lat = 1;
    repeat (9) step(1'b1, 1'b0, 32'd0, 32'd0);

    // Stall downstream for 5 cycles in HOLD, then release.
    force_lat = 2;
    go_to_hold();
    repeat (5) step(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (4) step(1'b1, 1'b0, 32'd0, 32'd0);

    // Redirect while waiting on a latency-3 response.
    force_lat = 3;
    go_to_fetch();
    step(1'b1, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b1, 32'h0000_0100, 32'h0000_0010);
    repeat (8) step(1'b1, 1'b0, 32'd0, 32'd0);

    // Redirect together with handshake in HOLD (backward branch).
    force_lat = 1;
    go_to_hold();
    step(1'b1, 1'b1, 32'h0000_0040, 32'hFFFF_FFF8);
    repeat (4) step(1'b1, 1'b0, 32'd0, 32'd0);

    // Discard in HOLD to reach the top of memory, then wrap to zero.
    go_to_hold();
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 32'd0);
    go_to_hold();
    repeat (4) step(1'b1, 1'b0, 32'd0, 32'd0);

    // Reset in the middle of a latency-4 wait.
    force_lat = 4;
    go_to_fetch();
    step(1'b1, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b0, 32'd0, 32'd0);
    do_reset();
    repeat (6) step(1'b1, 1'b0, 32'd0, 32'd0);

    // Random traffic: latency, stalls and redirects all randomized.
    force_lat = 0;
    repeat (3000) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
           $urandom, ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
